// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_pkg
// Description : Shared types and sizing helpers for the CSA reduction path.
//               resolver_state_t  - carry-save resolver FSM states
//               seg_count()       - number of SEG_LEN slices in a BIT_LEN word
// Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } resolver_state_t;

  // Slice count for a vector split into equal segments; callers guarantee
  // that bit_len is an exact multiple of seg_len.
  function automatic int seg_count(input int bit_len, input int seg_len);
    return bit_len / seg_len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/carry_propagate_segment.sv
`default_nettype none
// ============================================================================
// Module      : carry_propagate_segment
// Description : Combinational SEG_LEN-bit ripple slice of the final add.
// Ports       : a, b  [SEG_LEN-1:0]  in   segment operands
//               cin                  in   carry from the previous segment
//               s     [SEG_LEN-1:0]  out  segment sum
//               cout                 out  segment carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module carry_propagate_segment
  import csa_pkg::*;
#(
  parameter int SEG_LEN = 16
) (
  input  logic [SEG_LEN-1:0] a,
  input  logic [SEG_LEN-1:0] b,
  input  logic               cin,
  output logic [SEG_LEN-1:0] s,
  output logic               cout
);

  // One bit wider than a segment so the carry-out falls out of the add.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_LEN{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/carry_save_resolver.sv
`default_nettype none
// ============================================================================
// Module      : carry_save_resolver
// Description : Resolves one carry-save pair (sum, carry) into a binary
//               BIT_LEN+1 result, rippling SEG_LEN bits per clock so the
//               wide final add has no long carry chain. One operation in
//               flight; valid/ready handshakes on both sides.
// Ports       : clk                      in   clock, rising edge
//               reset                    in   asynchronous active-high reset
//               in_valid / in_ready      in/out  input handshake
//               in_sum   [BIT_LEN-1:0]   in   sum vector
//               in_carry [BIT_LEN-1:0]   in   carry vector at sum weight
//               out_valid / out_ready    out/in  output handshake
//               out_result [BIT_LEN:0]   out  in_sum + in_carry
// Revision    : 1.0 - initial release
// ============================================================================
module carry_save_resolver
  import csa_pkg::*;
#(
  parameter int BIT_LEN = 64,
  parameter int SEG_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_sum,
  input  logic [BIT_LEN-1:0] in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN:0]   out_result
);

  localparam int NUM_SEGS = seg_count(BIT_LEN, SEG_LEN);
  localparam int IDX_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGS - 1);

  if ((SEG_LEN < 1) || (BIT_LEN % SEG_LEN != 0)) begin : g_bad_seg_len
    $error("carry_save_resolver: BIT_LEN (%0d) must be a multiple of SEG_LEN (%0d)",
           BIT_LEN, SEG_LEN);
  end

  resolver_state_t      state_q,     state_d;
  logic [BIT_LEN-1:0]   sum_q,       sum_d;
  logic [BIT_LEN-1:0]   carry_vec_q, carry_vec_d;
  logic [IDX_W-1:0]     seg_idx_q,   seg_idx_d;
  logic                 carry_q,     carry_d;
  logic [BIT_LEN:0]     result_q,    result_d;

  logic [31:0]          seg_off;
  logic [SEG_LEN-1:0]   seg_a;
  logic [SEG_LEN-1:0]   seg_b;
  logic [SEG_LEN-1:0]   seg_s;
  logic                 seg_cout;
  logic                 capture;

  // Bit offset of the segment being resolved this cycle.
  assign seg_off = 32'(seg_idx_q) * 32'(SEG_LEN);
  assign seg_a   = sum_q[seg_off +: SEG_LEN];
  assign seg_b   = carry_vec_q[seg_off +: SEG_LEN];

  carry_propagate_segment #(
    .SEG_LEN (SEG_LEN)
  ) u_segment (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (carry_q),
    .s    (seg_s),
    .cout (seg_cout)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_vec_d = carry_vec_q;
    seg_idx_d   = seg_idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = ADD;
        end
      end

      ADD: begin
        result_d[seg_off +: SEG_LEN] = seg_s;
        carry_d   = seg_cout;
        seg_idx_d = seg_idx_q + IDX_W'(1);
        if (seg_idx_q == LAST_IDX) begin
          result_d[BIT_LEN] = seg_cout;
          state_d           = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // Accepting during the output handshake keeps back-to-back
        // throughput at one result per NUM_SEGS+1 cycles.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            capture = 1'b1;
            state_d = ADD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (capture) begin
      sum_d       = in_sum;
      carry_vec_d = in_carry;
      seg_idx_d   = '0;
      carry_d     = 1'b0;
    end

    // The FSM already sits in IDLE under reset; keep upstream from
    // believing a pair was taken while reset is still asserted.
    if (reset) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      carry_vec_q <= '0;
      seg_idx_q   <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_vec_q <= carry_vec_d;
      seg_idx_q   <= seg_idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
    end
  end

  assign out_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_save_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_save_resolver
// Description : Directed and randomised checks of carry_save_resolver at
//               SEG_LEN = 1, 16 and 64 (BIT_LEN = 64). Index 0/1/2 of the
//               signal arrays selects the SEG_LEN=1/16/64 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_save_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_a   [3];
  logic        in_ready_a   [3];
  logic [63:0] in_sum_a     [3];
  logic [63:0] in_carry_a   [3];
  logic        out_valid_a  [3];
  logic        out_ready_a  [3];
  logic [64:0] out_result_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  carry_save_resolver #(.BIT_LEN(64), .SEG_LEN(1)) u_dut_seg1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_sum(in_sum_a[0]), .in_carry(in_carry_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_result(out_result_a[0])
  );

  carry_save_resolver #(.BIT_LEN(64), .SEG_LEN(16)) u_dut_seg16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_sum(in_sum_a[1]), .in_carry(in_carry_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_result(out_result_a[1])
  );

  carry_save_resolver #(.BIT_LEN(64), .SEG_LEN(64)) u_dut_seg64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_sum(in_sum_a[2]), .in_carry(in_carry_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .out_result(out_result_a[2])
  );

  // Stimulus helper: offers one pair, waits for acceptance, then counts
  // clock edges (acceptance edge = 1) until out_valid rises. Leaves the
  // instance in DONE; out_ready is left as the caller set it.
  task automatic send_and_wait(input int inst, input logic [63:0] s, input logic [63:0] c,
                               output int lat, output logic [64:0] res, output bit ok);
    int guard;
    ok  = 1'b1;
    lat = 0;
    res = '0;
    @(posedge clk); #1;
    in_valid_a[inst] = 1'b1;
    in_sum_a[inst]   = s;
    in_carry_a[inst] = c;
    #1;
    guard = 0;
    while (!in_ready_a[inst] && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_ready_a[inst]) begin
      in_valid_a[inst] = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_a[inst] = 1'b0;
    lat = 1;
    while (!out_valid_a[inst] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok  = out_valid_a[inst];
    res = out_result_a[inst];
  endtask

  task automatic drain(input int inst);
    out_ready_a[inst] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[inst] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      in_sum_a[i]    = '0;
      in_carry_a[i]  = '0;
      out_ready_a[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready_a[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_ready inst%0d: got %b expected 0", i, in_ready_a[i]);
      end
      n_checks++;
      if (out_valid_a[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid inst%0d: got %b expected 0", i, out_valid_a[i]);
      end
      n_checks++;
      if (out_result_a[i] !== 65'h0) begin
        n_fail++; $display("FAIL reset_out_result inst%0d: got %h expected 0", i, out_result_a[i]);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready_a[i] !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_in_ready inst%0d: got %b expected 1", i, in_ready_a[i]);
      end
    end
  endtask

  task automatic test_full_ripple();
    int lat; logic [64:0] res; bit ok;
    out_ready_a[1] = 1'b0;
    send_and_wait(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, res, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_ripple_timeout: got no out_valid expected out_valid"); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL full_ripple_latency: got %0d expected 5", lat); end
    n_checks++;
    if (res !== 65'h1_0000_0000_0000_0000) begin
      n_fail++; $display("FAIL full_ripple_result: got %h expected 1_0000_0000_0000_0000", res);
    end
    drain(1);
  endtask

  task automatic test_no_carry();
    int lat; logic [64:0] res; bit ok;
    out_ready_a[1] = 1'b0;
    send_and_wait(1, 64'h1234, 64'h0002, lat, res, ok);
    n_checks++;
    if (!ok || res !== 65'h1236) begin
      n_fail++; $display("FAIL no_carry_result: got %h (valid %b) expected 1236", res, ok);
    end
    n_checks++;
    if (res[64] !== 1'b0) begin n_fail++; $display("FAIL no_carry_bit64: got %b expected 0", res[64]); end
    drain(1);
  endtask

  task automatic test_seg_configs();
    int lat; logic [64:0] res; bit ok;
    // Bit-serial: 64 ADD cycles.
    out_ready_a[0] = 1'b0;
    send_and_wait(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, res, ok);
    n_checks++;
    if (!ok || lat !== 65) begin n_fail++; $display("FAIL seg1_latency: got %0d (valid %b) expected 65", lat, ok); end
    n_checks++;
    if (res !== 65'h1_0000_0000_0000_0000) begin
      n_fail++; $display("FAIL seg1_result: got %h expected 1_0000_0000_0000_0000", res);
    end
    drain(0);
    // Whole word in one ADD cycle.
    out_ready_a[2] = 1'b0;
    send_and_wait(2, 64'hDEAD_BEEF_0000_0001, 64'h2152_4110_FFFF_FFFE, lat, res, ok);
    n_checks++;
    if (!ok || lat !== 2) begin n_fail++; $display("FAIL seg64_latency: got %0d (valid %b) expected 2", lat, ok); end
    n_checks++;
    if (res !== 65'h0_FFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL seg64_result: got %h expected 0_ffff_ffff_ffff_ffff", res);
    end
    drain(2);
  endtask

  task automatic test_backpressure();
    int lat; logic [64:0] res; bit ok;
    out_ready_a[1] = 1'b0;
    send_and_wait(1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1110, lat, res, ok);
    n_checks++;
    if (!ok || res !== 65'h0_1234_5678_9ABC_DEFF) begin
      n_fail++; $display("FAIL bp_result: got %h (valid %b) expected 0_1234_5678_9abc_deff", res, ok);
    end
    // A competing pair is offered throughout the stall and must be refused.
    in_valid_a[1] = 1'b1;
    in_sum_a[1]   = 64'h5;
    in_carry_a[1] = 64'h5;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (out_valid_a[1] !== 1'b1) begin
        n_fail++; $display("FAIL bp_out_valid cycle%0d: got %b expected 1", i, out_valid_a[1]);
      end
      n_checks++;
      if (out_result_a[1] !== 65'h0_1234_5678_9ABC_DEFF) begin
        n_fail++; $display("FAIL bp_hold cycle%0d: got %h expected 0_1234_5678_9abc_deff", i, out_result_a[1]);
      end
      n_checks++;
      if (in_ready_a[1] !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready cycle%0d: got %b expected 0", i, in_ready_a[1]);
      end
      @(posedge clk);
    end
    #1;
    in_valid_a[1]  = 1'b0;
    out_ready_a[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[1] = 1'b0;
    #1;
    n_checks++;
    if (out_valid_a[1] !== 1'b0 || in_ready_a[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_return_idle: got out_valid %b in_ready %b expected 0 1",
                         out_valid_a[1], in_ready_a[1]);
    end
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid_a[1] !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_phantom: got out_valid %b expected 0", out_valid_a[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] sums   [4];
    logic [63:0] carries[4];
    logic [64:0] exps   [4];
    int p = 0, q = 0, cyc = 0, last = 0;
    sums[0] = 64'hFFFF_FFFF_FFFF_FFFF; carries[0] = 64'h1;                   exps[0] = 65'h1_0000_0000_0000_0000;
    sums[1] = 64'h0000_0000_0000_1234; carries[1] = 64'h2;                   exps[1] = 65'h0_0000_0000_0000_1236;
    sums[2] = 64'h8000_0000_0000_0001; carries[2] = 64'h8000_0000_0000_0000; exps[2] = 65'h1_0000_0000_0000_0001;
    sums[3] = 64'h0000_FFFF_0000_FFFF; carries[3] = 64'h0000_0001_0000_0001; exps[3] = 65'h0_0001_0000_0001_0000;
    out_ready_a[1] = 1'b1;
    while (q < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (p < 4) begin
        in_valid_a[1] = 1'b1;
        in_sum_a[1]   = sums[p];
        in_carry_a[1] = carries[p];
      end else begin
        in_valid_a[1] = 1'b0;
      end
      #1;
      if (out_valid_a[1] && out_ready_a[1]) begin
        n_checks++;
        if (out_result_a[1] !== exps[q]) begin
          n_fail++; $display("FAIL b2b_result pair%0d: got %h expected %h", q, out_result_a[1], exps[q]);
        end
        if (q > 0) begin
          n_checks++;
          if (cyc - last !== 5) begin
            n_fail++; $display("FAIL b2b_spacing pair%0d: got %0d cycles expected 5", q, cyc - last);
          end
        end
        last = cyc;
        q++;
      end
      if (in_valid_a[1] && in_ready_a[1]) p++;
    end
    in_valid_a[1] = 1'b0;
    n_checks++;
    if (q !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 4", q); end
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid_a[1] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_duplicate: got out_valid %b expected 0", out_valid_a[1]);
    end
    out_ready_a[1] = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [64:0] res; bit ok;
    out_ready_a[1] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[1] = 1'b1;
    in_sum_a[1]   = 64'h0004_0003_0002_0001;
    in_carry_a[1] = 64'h0;
    @(posedge clk); #1;               // accepted; segment 0 next
    in_valid_a[1] = 1'b0;
    @(posedge clk);                   // segment 0 resolved
    @(posedge clk); #1;               // segment 1 resolved, segment 2 in progress
    n_checks++;
    if (out_valid_a[1] !== 1'b0 || out_result_a[1][31:0] !== 32'h0002_0001) begin
      n_fail++; $display("FAIL midop_partial: got valid %b low %h expected 0 00020001",
                         out_valid_a[1], out_result_a[1][31:0]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid_a[1] !== 1'b0 || out_result_a[1] !== 65'h0 || in_ready_a[1] !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: got valid %b result %h in_ready %b expected 0 0 0",
                         out_valid_a[1], out_result_a[1], in_ready_a[1]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready_a[1] !== 1'b1 || out_valid_a[1] !== 1'b0) begin
      n_fail++; $display("FAIL midop_release: got in_ready %b out_valid %b expected 1 0",
                         in_ready_a[1], out_valid_a[1]);
    end
    send_and_wait(1, 64'h1111_2222_3333_4444, 64'h0EEE_DDDD_CCCC_BBBC, lat, res, ok);
    n_checks++;
    if (!ok || lat !== 5 || res !== 65'h0_2000_0000_0000_0000) begin
      n_fail++; $display("FAIL midop_next_pair: got %h lat %0d valid %b expected 0_2000_0000_0000_0000 lat 5",
                         res, lat, ok);
    end
    drain(1);
  endtask

  task automatic test_random(input int inst, input int n, input int budget);
    logic [64:0] exp_q[$];
    int got = 0;
    fork
      begin : producer
        int          sent = 0;
        int          cyc  = 0;
        bit          pres = 1'b0;
        logic [63:0] s = '0;
        logic [63:0] c = '0;
        while (sent < n && cyc < budget) begin
          @(posedge clk); #1;
          cyc++;
          if (!pres && $urandom_range(0, 3) != 0) begin
            pres = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
              s = 64'hFFFF_FFFF_FFFF_FFFF;
              c = 64'($urandom_range(0, 3));
            end else begin
              s = {$urandom, $urandom};
              c = {$urandom, $urandom};
            end
          end
          in_valid_a[inst] = pres;
          in_sum_a[inst]   = s;
          in_carry_a[inst] = c;
          #1;
          if (pres && in_ready_a[inst]) begin
            exp_q.push_back({1'b0, s} + {1'b0, c});
            sent++;
            pres = 1'b0;
          end
        end
        @(posedge clk); #1;
        in_valid_a[inst] = 1'b0;
      end
      begin : consumer
        int          cyc = 0;
        logic [64:0] e;
        while (got < n && cyc < budget) begin
          @(posedge clk); #1;
          cyc++;
          out_ready_a[inst] = ($urandom_range(0, 3) != 0);
          #1;
          if (out_valid_a[inst] && out_ready_a[inst]) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_unexpected inst%0d: got %h expected no output", inst, out_result_a[inst]);
            end else begin
              e = exp_q.pop_front();
              if (out_result_a[inst] !== e) begin
                n_fail++; $display("FAIL rand_result inst%0d #%0d: got %h expected %h", inst, got, out_result_a[inst], e);
              end
            end
            got++;
          end
        end
        @(posedge clk); #1;
        out_ready_a[inst] = 1'b0;
      end
    join
    n_checks++;
    if (got !== n || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL rand_complete inst%0d: got %0d results (%0d pending) expected %0d",
                         inst, got, exp_q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_no_carry();
    test_seg_configs();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random(0, 150, 20000);
    test_random(1, 450, 10000);
    test_random(2, 400, 8000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
